// File: rtl/pcie_us_cfg_mgmt_resp_pkg.sv
// Shared types and config-space write rules for the cfg_mgmt responder model.
package pcie_us_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_RELEASE
  } cfg_state_e;

  localparam logic [9:0]  CFG_ID          = 10'd0;
  localparam logic [9:0]  CFG_CMD_STS     = 10'd1;
  localparam logic [9:0]  CFG_BAR0        = 10'd4;
  localparam int          CFG_BAR_NUM     = 6;
  localparam logic [31:0] CFG_CMD_STS_RST = 32'h0010_0000;

  localparam logic [31:0] WMASK_CMD_STS = 32'hF900_0547;
  localparam logic [31:0] W1C_CMD_STS   = 32'hF900_0000;
  localparam int          BAR_APERTURE  = 24;

  function automatic logic [31:0] wmask_for(input logic [9:0] addr);
    logic [31:0] m;
    m = '1;
    if (addr == CFG_ID)
      m = '0;
    else if (addr == CFG_CMD_STS)
      m = WMASK_CMD_STS;
    else if (addr >= CFG_BAR0 && addr < CFG_BAR0 + 10'(CFG_BAR_NUM))
      m = ~((32'd1 << BAR_APERTURE) - 32'd1);
    return m;
  endfunction

  // Byte-enabled merge; W1C bits clear where the written bit is 1.
  function automatic logic [31:0] cfg_merge(input logic [31:0] old_v,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be,
                                            input logic [9:0]  addr);
    logic [31:0] m, w1c;
    m   = wmask_for(addr) & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    w1c = (addr == CFG_CMD_STS) ? (W1C_CMD_STS & m) : 32'h0;
    return (old_v & ~m) | (wdata & m & ~w1c) | (old_v & w1c & ~wdata);
  endfunction

endpackage

// File: rtl/pcie_us_cfg_mgmt_resp_if.sv
// cfg_mgmt request/response bundle; master = requester, slave = responder.
interface pcie_us_cfg_mgmt_resp_if;
  logic [9:0]  cfg_mgmt_addr;
  logic [7:0]  cfg_mgmt_function_number;
  logic        cfg_mgmt_write;
  logic [31:0] cfg_mgmt_write_data;
  logic [3:0]  cfg_mgmt_byte_enable;
  logic        cfg_mgmt_read;
  logic [31:0] cfg_mgmt_read_data;
  logic        cfg_mgmt_read_write_done;
  logic        proto_err;

  modport master (
    output cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done, proto_err
  );

  modport slave (
    input  cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable, cfg_mgmt_read,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done, proto_err
  );
endinterface

// File: rtl/pcie_us_cfg_mgmt_resp_regfile.sv
// Per-function config dword storage: byte-masked/W1C write port, registered read port.
module pcie_us_cfg_regfile
  import pcie_us_cfg_pkg::*;
#(
  parameter int          FUNC_COUNT = 1,
  parameter int          REG_COUNT  = 64,
  parameter logic [15:0] VENDOR_ID  = 16'h10ee,
  parameter logic [15:0] DEVICE_ID  = 16'h9038
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_en,
  input  logic        acc_we,
  input  logic [7:0]  acc_func,
  input  logic [9:0]  acc_addr,
  input  logic [31:0] acc_wdata,
  input  logic [3:0]  acc_be,
  output logic [31:0] rd_data
);

  typedef logic [FUNC_COUNT-1:0][REG_COUNT-1:0][31:0] mem_t;

  function automatic mem_t rst_image();
    mem_t img;
    img = '0;
    for (int f = 0; f < FUNC_COUNT; f++) begin
      img[f][0] = {DEVICE_ID + 16'(f), VENDOR_ID};
      img[f][1] = CFG_CMD_STS_RST;
    end
    return img;
  endfunction

  localparam mem_t MEM_RST = rst_image();

  mem_t        mem_q, mem_d;
  logic [31:0] rd_q, rd_d;
  logic        func_ok, addr_ok;

  assign func_ok = int'(acc_func) < FUNC_COUNT;
  assign addr_ok = int'(acc_addr) < REG_COUNT;
  assign rd_data = rd_q;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    if (acc_en) begin
      if (!acc_we) begin
        // Absent functions float high like an unpopulated PCIe function.
        rd_d = func_ok ? 32'h0 : 32'hFFFF_FFFF;
      end
      for (int f = 0; f < FUNC_COUNT; f++) begin
        for (int a = 0; a < REG_COUNT; a++) begin
          if (func_ok && addr_ok && acc_func == 8'(f) && acc_addr == 10'(a)) begin
            if (acc_we)
              mem_d[f][a] = cfg_merge(mem_q[f][a], acc_wdata, acc_be, acc_addr);
            else
              rd_d = mem_q[f][a];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= MEM_RST;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/pcie_us_cfg_mgmt_resp.sv
// cfg_mgmt responder: handshake FSM with fixed response latency over a config regfile.
// Optional counters enabled by PCIE_US_CFG_MGMT_RESP_STATS_EN.
module pcie_us_cfg_mgmt_resp
  import pcie_us_cfg_pkg::*;
#(
  parameter int          FUNC_COUNT   = 1,
  parameter int          REG_COUNT    = 64,
  parameter int          RESP_LATENCY = 4,
  parameter logic [15:0] VENDOR_ID    = 16'h10ee,
  parameter logic [15:0] DEVICE_ID    = 16'h9038
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef PCIE_US_CFG_MGMT_RESP_STATS_EN
  output logic [31:0]              stat_rd_count,
  output logic [31:0]              stat_wr_count,
  output logic [15:0]              stat_err_count,
`endif
  pcie_us_cfg_mgmt_resp_if.slave   cfg
);

  cfg_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  lat_addr_q, lat_addr_d;
  logic [7:0]  lat_func_q, lat_func_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  lat_be_q, lat_be_d;
  logic        lat_we_q, lat_we_d;
  logic        err_seen_q, err_seen_d;
  logic        proto_err_q, proto_err_d;
  logic        acc_en, viol, done;
  logic [31:0] rf_rdata;

  // Anything the requester moves away from the latched request while waiting.
  assign viol = (cfg.cfg_mgmt_addr != lat_addr_q)
              | (cfg.cfg_mgmt_function_number != lat_func_q)
              | (lat_we_q ? (!cfg.cfg_mgmt_write
                             | (cfg.cfg_mgmt_write_data != lat_wdata_q)
                             | (cfg.cfg_mgmt_byte_enable != lat_be_q))
                          : !cfg.cfg_mgmt_read);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_func_d  = lat_func_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    lat_we_d    = lat_we_q;
    err_seen_d  = err_seen_q;
    proto_err_d = 1'b0;
    acc_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        err_seen_d = 1'b0;
        if (cfg.cfg_mgmt_read || cfg.cfg_mgmt_write) begin
          lat_addr_d  = cfg.cfg_mgmt_addr;
          lat_func_d  = cfg.cfg_mgmt_function_number;
          lat_wdata_d = cfg.cfg_mgmt_write_data;
          lat_be_d    = cfg.cfg_mgmt_byte_enable;
          lat_we_d    = cfg.cfg_mgmt_write;
          cnt_d       = 4'(RESP_LATENCY - 1);
          state_d     = ST_BUSY;
          if (cfg.cfg_mgmt_read && cfg.cfg_mgmt_write) begin
            proto_err_d = 1'b1;
            err_seen_d  = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (viol && !err_seen_q) begin
          proto_err_d = 1'b1;
          err_seen_d  = 1'b1;
        end
        if (cnt_q == 4'd0) begin
          acc_en  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!cfg.cfg_mgmt_read && !cfg.cfg_mgmt_write)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lat_addr_q  <= '0;
      lat_func_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      lat_we_q    <= 1'b0;
      err_seen_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_func_q  <= lat_func_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      lat_we_q    <= lat_we_d;
      err_seen_q  <= err_seen_d;
      proto_err_q <= proto_err_d;
    end
  end

  pcie_us_cfg_regfile #(
    .FUNC_COUNT (FUNC_COUNT),
    .REG_COUNT  (REG_COUNT),
    .VENDOR_ID  (VENDOR_ID),
    .DEVICE_ID  (DEVICE_ID)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_en    (acc_en),
    .acc_we    (lat_we_q),
    .acc_func  (lat_func_q),
    .acc_addr  (lat_addr_q),
    .acc_wdata (lat_wdata_q),
    .acc_be    (lat_be_q),
    .rd_data   (rf_rdata)
  );

  assign done                         = (state_q == ST_DONE);
  assign cfg.cfg_mgmt_read_write_done = done;
  assign cfg.cfg_mgmt_read_data       = (done && !lat_we_q) ? rf_rdata : 32'h0;
  assign cfg.proto_err                = proto_err_q;

`ifdef PCIE_US_CFG_MGMT_RESP_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (done && !lat_we_q && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 32'd1;
    if (done && lat_we_q && wr_cnt_q != '1)  wr_cnt_d = wr_cnt_q + 32'd1;
    if (proto_err_q && err_cnt_q != '1)      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_rd_count  = rd_cnt_q;
  assign stat_wr_count  = wr_cnt_q;
  assign stat_err_count = err_cnt_q;
`endif

endmodule
